// File: rtl/cnn_bram_pkg.sv
// Shared BRAM constants and the reader FSM state type for the CNN BRAM readers.
package cnn_bram_pkg;

  localparam int unsigned BRAM_ADDR_W     = 32;
  localparam int unsigned BRAM_DATA_W     = 32;
  localparam int unsigned BRAM_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } rd_state_e;

endpackage

// File: rtl/second_order_conv_bram_reader_if.sv
// BRAM port-B bus plus the outgoing valid/ready stream of the second-order conv reader.
interface second_order_conv_bram_reader_if
  import cnn_bram_pkg::*;
#(
  parameter int unsigned ADDR_W = BRAM_ADDR_W,
  parameter int unsigned DATA_W = BRAM_DATA_W
);
  logic [ADDR_W-1:0]          bram_addr;
  logic                       bram_en;
  logic [BRAM_WORD_BYTES-1:0] bram_we;
  logic [DATA_W-1:0]          bram_din;
  logic [DATA_W-1:0]          bram_dout;
  logic [DATA_W-1:0]          m_tdata;
  logic                       m_tvalid;
  logic                       m_tready;
  logic                       m_tlast;

  // Reader side: drives BRAM port B and the stream master.
  modport master (
    output bram_addr, bram_en, bram_we, bram_din,
    input  bram_dout,
    output m_tdata, m_tvalid, m_tlast,
    input  m_tready
  );

  // BRAM plus downstream consumer side.
  modport slave (
    input  bram_addr, bram_en, bram_we, bram_din,
    output bram_dout,
    input  m_tdata, m_tvalid, m_tlast,
    output m_tready
  );
endinterface

// File: rtl/second_order_conv_bram_reader_skid_fifo.sv
// Small synchronous FIFO absorbing BRAM read data; push is registered, head is visible next cycle.
module so_conv_skid_fifo #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
    rd_d  = do_pop  ? ptr_inc(rd_q) : rd_q;
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + CNT_W'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
  end

  // Storage and pointer registers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= din_i;
    end
  end
endmodule

// File: rtl/second_order_conv_bram_reader.sv
// Drains the second-order conv result BRAM (port B) into a valid/ready stream.
// Reads are credit-limited so the skid FIFO never overflows under backpressure.
// Optional macro SO_CONV_RD_CHECKSUM_EN adds a running checksum output of streamed words.
module second_order_conv_bram_reader
  import cnn_bram_pkg::*;
#(
  parameter int unsigned ADDR_W       = BRAM_ADDR_W,
  parameter int unsigned DATA_W       = BRAM_DATA_W,
  parameter int unsigned LEN_W        = 16,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH   = READ_LATENCY + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
`ifdef SO_CONV_RD_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  second_order_conv_bram_reader_if.master bus
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

  rd_state_e               state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        issued_q, issued_d;
  logic [LEN_W-1:0]        out_cnt_q, out_cnt_d;
  logic [ADDR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]       addr_q;
  logic                    done_q, done_d;
  logic [READ_LATENCY-1:0] infl_q, infl_d;

  logic                    issue, start_acc, credit_ok, pop, push;
  logic [ADDR_W-1:0]       issue_addr;
  logic [OCC_W-1:0]        occ;
  logic [DATA_W-1:0]       fifo_dout;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_full, fifo_empty;

  so_conv_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (bus.bram_dout),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign push          = infl_q[READ_LATENCY-1];
  assign pop           = !fifo_empty && bus.m_tready;
  assign bus.m_tvalid  = !fifo_empty;
  assign bus.m_tdata   = fifo_dout;
  assign bus.m_tlast   = !fifo_empty && (out_cnt_q == len_q - LEN_W'(1));
  assign bus.bram_en   = issue;
  assign bus.bram_addr = issue ? issue_addr : addr_q;
  assign bus.bram_we   = '0;
  assign bus.bram_din  = '0;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

  // Words already claimed: FIFO entries plus reads still in the BRAM pipeline.
  always_comb begin
    occ = OCC_W'(fifo_count);
    for (int unsigned i = 0; i < READ_LATENCY; i++) occ = occ + OCC_W'(infl_q[i]);
    credit_ok = (occ < OCC_W'(FIFO_DEPTH)) && !fifo_full;
  end

  // In-flight valid shift register: one bit per outstanding read.
  always_comb begin
    infl_d[0] = issue;
    for (int unsigned i = 1; i < READ_LATENCY; i++) infl_d[i] = infl_q[i-1];
  end

  // FSM next state, read issue and stream word counter.
  // The first read goes out in the start cycle itself so data lands READ_LATENCY+1 cycles later.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    rd_ptr_d   = rd_ptr_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    issue_addr = rd_ptr_q;
    start_acc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          len_d     = len;
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            issue      = 1'b1;
            issue_addr = base_addr;
            issued_d   = LEN_W'(1);
            rd_ptr_d   = base_addr + ADDR_W'(BRAM_WORD_BYTES);
            state_d    = (len == LEN_W'(1)) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if ((issued_q < len_q) && credit_ok) begin
          issue    = 1'b1;
          issued_d = issued_q + LEN_W'(1);
          rd_ptr_d = rd_ptr_q + ADDR_W'(BRAM_WORD_BYTES);
          if (issued_d == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && bus.m_tlast) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) issue = 1'b0;
    out_cnt_d = start_acc ? '0 : (pop ? out_cnt_q + LEN_W'(1) : out_cnt_q);
  end

  // Control and address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      issued_q  <= '0;
      out_cnt_q <= '0;
      rd_ptr_q  <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      infl_q    <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      out_cnt_q <= out_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      done_q    <= done_d;
      infl_q    <= infl_d;
      if (issue) addr_q <= issue_addr;
    end
  end

`ifdef SO_CONV_RD_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  // Checksum clears on an accepted start and sums every handshaken word.
  always_comb begin
    csum_d = csum_q;
    if (start_acc) csum_d = '0;
    else if (pop)  csum_d = csum_q + fifo_dout;
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  assign checksum = csum_q;
`endif
endmodule

// File: tb/tb_second_order_conv_bram_reader.sv
// Scoreboard bench for second_order_conv_bram_reader: DUT A (READ_LATENCY=1), DUT B (READ_LATENCY=2).
module tb_second_order_conv_bram_reader;
  import cnn_bram_pkg::*;

  localparam int unsigned AW = 32, DW = 32, LW = 16;
  localparam int DEPTH_A = 3;
  localparam int BUDGET  = 400;

  typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endfunction

  function automatic void fail(input string name, input int got);
    checks++;
    failures++;
    $display("FAIL %s: got %0d, expected none", name, got);
  endfunction

  // ---------------- DUT A ----------------
  logic          a_start;
  logic [AW-1:0] a_base;
  logic [LW-1:0] a_len;
  logic          a_busy, a_done;
`ifdef SO_CONV_RD_CHECKSUM_EN
  logic [DW-1:0] a_csum;
`endif
  second_order_conv_bram_reader_if #(.ADDR_W(AW), .DATA_W(DW)) a_if ();
  second_order_conv_bram_reader #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .READ_LATENCY(1), .FIFO_DEPTH(DEPTH_A)
  ) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .base_addr(a_base), .len(a_len),
    .busy(a_busy), .done(a_done),
`ifdef SO_CONV_RD_CHECKSUM_EN
    .checksum(a_csum),
`endif
    .bus(a_if)
  );

  logic [DW-1:0] a_mem [256];
  always @(posedge clk) if (a_if.bram_en) a_if.bram_dout <= a_mem[a_if.bram_addr[9:2]];

  // ---------------- DUT B ----------------
  logic          b_start;
  logic [AW-1:0] b_base;
  logic [LW-1:0] b_len;
  logic          b_busy, b_done;
`ifdef SO_CONV_RD_CHECKSUM_EN
  logic [DW-1:0] b_csum;
`endif
  second_order_conv_bram_reader_if #(.ADDR_W(AW), .DATA_W(DW)) b_if ();
  second_order_conv_bram_reader #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .READ_LATENCY(2), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .base_addr(b_base), .len(b_len),
    .busy(b_busy), .done(b_done),
`ifdef SO_CONV_RD_CHECKSUM_EN
    .checksum(b_csum),
`endif
    .bus(b_if)
  );

  logic [DW-1:0] b_mem [256];
  logic [DW-1:0] b_s1;
  always @(posedge clk) begin
    if (b_if.bram_en) b_s1 <= b_mem[b_if.bram_addr[9:2]];
    b_if.bram_dout <= b_s1;
  end

  // ---------------- scoreboards / monitors ----------------
  beat_t         a_exp[$], b_exp[$];
  logic [AW-1:0] a_aexp[$], b_aexp[$];
  logic [DW-1:0] a_csum_exp = '0, b_csum_exp = '0;
  int a_beats = 0, a_dones = 0, a_occ = 0, a_first = -1, a_last = -1, a_en_first = -1, a_en_last = -1, a_done_cyc = -1;
  int b_dones = 0, b_first = -1, b_last = -1, b_done_cyc = -1;
  logic a_stall = 1'b0, a_saw_busy = 1'b0, a_saw_en = 1'b0, a_saw_valid = 1'b0;
  logic [DW-1:0] a_hold = '0;

  // Monitor A: address order, credit bound, beat data/last, stall stability, done timing.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      a_occ   = 0;
      a_stall = 1'b0;
    end else begin
      if (a_busy) a_saw_busy = 1'b1;
      if (a_if.bram_en) a_saw_en = 1'b1;
      if (a_if.m_tvalid) a_saw_valid = 1'b1;
      if (a_if.bram_en) begin
        chk("a_credit", 64'(a_occ < DEPTH_A), 64'd1);
        if (a_aexp.size() == 0) fail("a_extra_read", int'(a_if.bram_addr));
        else chk("a_bram_addr", 64'(a_if.bram_addr), 64'(a_aexp.pop_front()));
        if (a_en_first < 0) a_en_first = cyc;
        a_en_last = cyc;
      end
      if (a_stall) begin
        chk("a_stall_valid", 64'(a_if.m_tvalid), 64'd1);
        chk("a_stall_data", 64'(a_if.m_tdata), 64'(a_hold));
      end
      if (a_if.m_tvalid && a_if.m_tready) begin
        if (a_exp.size() == 0) fail("a_extra_beat", int'(a_if.m_tdata));
        else begin
          e = a_exp.pop_front();
          chk("a_tdata", 64'(a_if.m_tdata), 64'(e.data));
          chk("a_tlast", 64'(a_if.m_tlast), 64'(e.last));
        end
        if (a_first < 0) a_first = cyc;
        a_last = cyc;
        a_beats++;
      end
      a_stall = a_if.m_tvalid && !a_if.m_tready;
      a_hold  = a_if.m_tdata;
      a_occ   = a_occ + (a_if.bram_en ? 1 : 0) - ((a_if.m_tvalid && a_if.m_tready) ? 1 : 0);
      if (a_done) begin
        a_dones++;
        a_done_cyc = cyc;
        chk("a_busy_at_done", 64'(a_busy), 64'd0);
`ifdef SO_CONV_RD_CHECKSUM_EN
        chk("a_checksum", 64'(a_csum), 64'(a_csum_exp));
`endif
      end
    end
  end

  // Monitor B: addresses, beats, done.
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (b_if.bram_en) begin
        if (b_aexp.size() == 0) fail("b_extra_read", int'(b_if.bram_addr));
        else chk("b_bram_addr", 64'(b_if.bram_addr), 64'(b_aexp.pop_front()));
      end
      if (b_if.m_tvalid && b_if.m_tready) begin
        if (b_exp.size() == 0) fail("b_extra_beat", int'(b_if.m_tdata));
        else begin
          e = b_exp.pop_front();
          chk("b_tdata", 64'(b_if.m_tdata), 64'(e.data));
          chk("b_tlast", 64'(b_if.m_tlast), 64'(e.last));
        end
        if (b_first < 0) b_first = cyc;
        b_last = cyc;
      end
      if (b_done) begin
        b_dones++;
        b_done_cyc = cyc;
`ifdef SO_CONV_RD_CHECKSUM_EN
        chk("b_checksum", 64'(b_csum), 64'(b_csum_exp));
`endif
      end
    end
  end

  // ---------------- stream ready driver for A ----------------
  int tr_mode = 0;
  int tr_ph = 0;
  initial begin
    a_if.m_tready = 1'b1;
    b_if.m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tr_ph++;
      a_if.m_tready = (tr_mode == 0) ? 1'b1 : (((tr_ph / 3) % 2) == 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic a_run(input logic [AW-1:0] base, input int len, output int s_cyc);
    logic [AW-1:0] ad;
    @(posedge clk); #1;
    a_first = -1; a_last = -1; a_en_first = -1; a_en_last = -1;
    a_csum_exp = '0;
    for (int i = 0; i < len; i++) begin
      ad = base + AW'(4 * i);
      a_aexp.push_back(ad);
      a_exp.push_back(beat_t'{data: a_mem[ad[9:2]], last: (i == len - 1)});
      a_csum_exp = a_csum_exp + a_mem[ad[9:2]];
    end
    a_base = base; a_len = LW'(len); a_start = 1'b1; s_cyc = cyc;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic a_wait_done(input int prev);
    int n = 0;
    while (a_dones == prev && n < BUDGET) begin @(posedge clk); n++; end
    if (a_dones == prev) fail("a_done_timeout", n);
  endtask

  int s, prev, pbeats;
  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_base = '0; a_len = '0;
    b_start = 1'b0; b_base = '0; b_len = '0;
    for (int i = 0; i < 256; i++) begin a_mem[i] = 32'hDEAD_0000 | i; b_mem[i] = 32'hBEEF_0000 | i; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_bram_en", 64'(a_if.bram_en), 64'd0);
    chk("rst_bram_addr", 64'(a_if.bram_addr), 64'd0);
    chk("rst_tvalid", 64'(a_if.m_tvalid), 64'd0);
    chk("rst_tlast", 64'(a_if.m_tlast), 64'd0);
    chk("rst_tdata", 64'(a_if.m_tdata), 64'd0);
    chk("rst_b_tvalid", 64'(b_if.m_tvalid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: base 0x100, len 4, full ready.
    for (int i = 0; i < 4; i++) a_mem[32'h40 + i] = 32'hA0 + i;
    prev = a_dones;
    a_run(32'h100, 4, s);
    a_wait_done(prev);
    chk("t1_first_latency", 64'(a_first - s), 64'd2);
    chk("t1_beat_span", 64'(a_last - a_first), 64'd3);
    chk("t1_addr_span", 64'(a_en_last - a_en_first), 64'd3);
    chk("t1_done_cyc", 64'(a_done_cyc), 64'(a_last + 1));
    chk("t1_left", 64'(a_exp.size() + a_aexp.size()), 64'd0);

    // T2: len 16 with ready toggling every 3 cycles.
    for (int i = 0; i < 16; i++) a_mem[32'h80 + i] = 32'h5A00_0000 + 32'h0101 * i;
    tr_mode = 1;
    prev = a_dones;
    a_run(32'h200, 16, s);
    a_wait_done(prev);
    tr_mode = 0;
    chk("t2_done_cyc", 64'(a_done_cyc), 64'(a_last + 1));
    chk("t2_left", 64'(a_exp.size() + a_aexp.size()), 64'd0);

    // T3: len 0.
    @(posedge clk); #1;
    a_saw_busy = 1'b0; a_saw_en = 1'b0; a_saw_valid = 1'b0;
    prev = a_dones;
    a_run(32'h400, 0, s);
    a_wait_done(prev);
    repeat (3) @(posedge clk);
    chk("t3_done_cyc", 64'(a_done_cyc), 64'(s + 1));
    chk("t3_dones", 64'(a_dones), 64'(prev + 1));
    chk("t3_busy_never", 64'(a_saw_busy), 64'd0);
    chk("t3_en_never", 64'(a_saw_en), 64'd0);
    chk("t3_valid_never", 64'(a_saw_valid), 64'd0);

    // T4: second start two cycles into a len 8 transfer is ignored.
    for (int i = 0; i < 8; i++) a_mem[32'h40 + i] = 32'h7700_0000 + i;
    prev = a_dones; pbeats = a_beats;
    a_run(32'h500, 8, s);
    @(posedge clk); #1;
    a_base = 32'h600; a_len = LW'(3); a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    a_wait_done(prev);
    repeat (12) @(posedge clk);
    chk("t4_beats", 64'(a_beats - pbeats), 64'd8);
    chk("t4_dones", 64'(a_dones), 64'(prev + 1));
    chk("t4_left", 64'(a_exp.size() + a_aexp.size()), 64'd0);

    // T5: reset after 3 beats, then a wrapping len 2 transfer.
    for (int i = 0; i < 8; i++) a_mem[32'hC0 + i] = 32'h3300_0000 + i;
    prev = a_dones; pbeats = a_beats;
    a_run(32'h300, 8, s);
    begin
      int n = 0;
      while (a_beats < pbeats + 3 && n < BUDGET) begin @(posedge clk); n++; end
      if (a_beats < pbeats + 3) fail("t5_beat_timeout", n);
    end
    #1;
    rst = 1'b1;
    a_exp.delete(); a_aexp.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    a_saw_valid = 1'b0;
    repeat (4) @(posedge clk);
    chk("t5_no_done", 64'(a_dones), 64'(prev));
    chk("t5_no_stale", 64'(a_saw_valid), 64'd0);
    chk("t5_busy_after_rst", 64'(a_busy), 64'd0);
    a_mem[255] = 32'hCAFE_0001; a_mem[0] = 32'hCAFE_0002;
    prev = a_dones;
    a_run(32'hFFFF_FFFC, 2, s);
    a_wait_done(prev);
    chk("t5_left", 64'(a_exp.size() + a_aexp.size()), 64'd0);
    chk("t5_first_latency", 64'(a_first - s), 64'd2);

    // T6: DUT B, READ_LATENCY 2, data 1..5.
    for (int i = 0; i < 5; i++) b_mem[32'h10 + i] = 32'(i + 1);
    @(posedge clk); #1;
    b_csum_exp = '0;
    for (int i = 0; i < 5; i++) begin
      b_aexp.push_back(32'h40 + 32'(4 * i));
      b_exp.push_back(beat_t'{data: 32'(i + 1), last: (i == 4)});
      b_csum_exp = b_csum_exp + 32'(i + 1);
    end
    prev = b_dones;
    b_base = 32'h40; b_len = LW'(5); b_start = 1'b1; s = cyc;
    @(posedge clk); #1;
    b_start = 1'b0;
    begin
      int n = 0;
      while (b_dones == prev && n < BUDGET) begin @(posedge clk); n++; end
      if (b_dones == prev) fail("b_done_timeout", n);
    end
    chk("t6_first_latency", 64'(b_first - s), 64'd3);
    chk("t6_beat_span", 64'(b_last - b_first), 64'd4);
    chk("t6_done_cyc", 64'(b_done_cyc), 64'(b_last + 1));
    chk("t6_left", 64'(b_exp.size() + b_aexp.size()), 64'd0);
    chk("t6_csum_model", 64'(b_csum_exp), 64'd15);
`ifdef SO_CONV_RD_CHECKSUM_EN
    repeat (3) @(posedge clk);
    chk("t6_csum_stable", 64'(b_csum), 64'd15);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
